riscv_lsu_ctrl: RTL
===================

Name: riscv_lsu_ctrl

Overview:
Load/store sequencing controller between the execute stage and a word-wide data RAM with a valid/ready request channel and a separate read-return strobe. It accepts one load or store per transaction and generates the word-aligned address, byte enables and lane-replicated write data. For loads it shifts the returned word by byte offset and applies byte/halfword masking or sign-extension. It detects misaligned accesses, illegal funct3 values and memory timeouts, and holds the pipeline via busy while a transaction is outstanding.

Parameters:
WORD_LENGTH, 32, data/address width; only 32 is supported.
WAIT_LIMIT, 255, maximum cycles spent in ISSUE plus WAIT before a timeout error; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  pipeline request strobe
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 funct3 (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
mem_valid  out  1  RAM request valid
mem_ready  in  1  RAM accepts request
mem_we  out  1  RAM write enable
mem_be  out  4  byte enables
mem_addr  out  32  word address, bits [1:0] = 0
mem_wdata  out  32  lane-replicated write data
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  misaligned, illegal funct3 or timeout; valid with rsp_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. req_ready = (state == IDLE).
- Reset (asynchronous, any state): state goes to IDLE, timeout counter goes to 0, and every output register clears to 0. This includes mem_valid, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_rdata and rsp_err. An outstanding RAM transaction is abandoned, and a later mem_rvalid is ignored.
- IDLE, on req_valid:
  - Latch req_we, req_funct3, req_addr[1:0] and req_wdata.
  - Set mem_addr = {req_addr[31:2], 2'b00}.
  - Misaligned means: halfword with addr[0] = 1, word with addr[1:0] != 0, or funct3 outside the legal set for the operation (stores: 000–010; loads: 000, 001, 010, 100, 101).
  - If misaligned: go to RESP with rsp_err = 1. No mem_valid is ever raised.
  - Otherwise: go to ISSUE.
- ISSUE:
  - mem_valid = 1.
  - mem_we, mem_be, mem_addr and mem_wdata are held stable until mem_valid && mem_ready.
  - Byte enables: byte = 4'b0001 << off; half = 4'b0011 << off; word = 4'b1111.
  - Write data: byte is replicated 4×, half is replicated 2×, word passes through.
  - Loads drive mem_be by the same rule.
  - On handshake: mem_valid drops next cycle. A store goes to RESP; a load goes to WAIT.
- WAIT:
  - On mem_rvalid: shifted = mem_rdata >> (8*off).
  - LB: sign-extend shifted[7:0]. LBU: zero-extend shifted[7:0].
  - LH: sign-extend shifted[15:0]. LHU: zero-extend shifted[15:0]. LW: use shifted as-is.
  - Register the result into rsp_rdata and go to RESP.
  - mem_rvalid is ignored in all states except WAIT. It never arrives in the handshake cycle itself.
- Timeout:
  - The counter increments each cycle in ISSUE or WAIT and clears on entry to ISSUE.
  - When WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT: go to RESP with rsp_err = 1 and drop mem_valid.
  - If the timeout and a handshake or mem_rvalid occur in the same cycle, the handshake or rvalid wins.
- RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE. There is no response backpressure. rsp_rdata and rsp_err hold their values until the next RESP.
- Latency: accept at cycle N. Store with mem_ready already high: handshake at N+1, rsp_valid at N+2. Load with rvalid at N+2: rsp_valid at N+3. Misaligned: rsp_valid at N+1.
- Back-to-back: a new request is accepted in the cycle after RESP (IDLE).

Test Plan:
- LB at addr 0x1003, mem_rdata 0x80FF1234 -> mem_be 4'b1000, mem_addr 0x1000, rsp_rdata 0xFFFFFF80, rsp_err 0.
- LHU at addr 0x2002, mem_rdata 0x80FF1234 -> mem_be 4'b1100, rsp_rdata 0x000080FF. LH at the same address -> 0xFFFF80FF.
- SB at addr 0x0001, req_wdata 0x123456AB -> mem_be 4'b0010, mem_wdata 0xABABABAB, mem_we 1, rsp_valid two cycles after accept.
- LW at addr 0x0006 -> no mem_valid, rsp_valid 1 cycle after accept, rsp_err 1, rsp_rdata 0.
- SW with mem_ready low for 3 cycles -> mem_valid and all mem_* outputs stable for 4 cycles. With WAIT_LIMIT = 4 and mem_rvalid never asserted on a load -> rsp_err 1 after 4 cycles in ISSUE/WAIT.
- rst pulsed mid-WAIT, then mem_rvalid -> outputs 0, req_ready 1 immediately, no rsp_valid generated.

Source files
------------

// File: rtl/riscv_lsu_ctrl.sv
// rtl/riscv_lsu_ctrl.sv - RV32 load/store sequencer between the execute stage and a word-wide data RAM
// Aligns requests onto the word bus, replicates store lanes and extracts/extends load results.
module riscv_lsu_ctrl #(
  parameter int WORD_LENGTH = 32,
  parameter int WAIT_LIMIT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   mem_we,
  output logic [3:0]             mem_be,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic                   mem_rvalid,
  input  logic [WORD_LENGTH-1:0] mem_rdata,
  output logic                   rsp_valid,
  output logic [WORD_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] cnt_q;
  logic        mem_valid_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        req_bad_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted_d;
  logic [31:0] load_d;
  logic        timeout_d;

  // Illegal funct3 for the operation or an unaligned halfword/word access.
  always_comb begin
    req_bad_d = 1'b0;
    if (req_we) begin
      req_bad_d = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      req_bad_d = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    end
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) req_bad_d = 1'b1;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) req_bad_d = 1'b1;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << req_addr[1:0];
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted_d = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
      3'b100:  load_d = {24'd0, shifted_d[7:0]};
      3'b001:  load_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
      3'b101:  load_d = {16'd0, shifted_d[15:0]};
      default: load_d = shifted_d;
    endcase
  end

  // The counter is about to reach the limit on this cycle's increment.
  assign timeout_d = (WAIT_LIMIT != 0) && ((cnt_q + 32'd1) == 32'(WAIT_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      cnt_q       <= 32'd0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            funct3_q   <= req_funct3;
            off_q      <= req_addr[1:0];
            mem_addr_q <= {req_addr[31:2], 2'b00};
            if (req_bad_d) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'd0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= S_ISSUE;
              cnt_q       <= 32'd0;
              mem_valid_q <= 1'b1;
              mem_we_q    <= req_we;
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        S_ISSUE: begin
          cnt_q <= cnt_q + 32'd1;
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            if (mem_we_q) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'd0;
              rsp_err_q   <= 1'b0;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (timeout_d) begin
            mem_valid_q <= 1'b0;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 32'd1;
          if (mem_rvalid) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_d;
            rsp_err_q   <= 1'b0;
          end else if (timeout_d) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b1;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
